// File: rtl/uart_tx_if.sv
// Request/line bundle between the byte source and the UART transmitter.
// The source (master) drives the request, and the transmitter (slave) drives the serial line and status.
interface uart_tx_if;
    logic       i_start;
    logic [0:7] i_uart_data;
    logic       o_tx;
    logic       o_busy;
    logic       o_done;

    modport master (output i_start, output i_uart_data, input o_tx, input o_busy, input o_done);
    modport slave  (input i_start, input i_uart_data, output o_tx, output o_busy, output o_done);
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits (numeric LSB first), optional parity, and 1 or 2 stop bits.
// Requests that arrive while a frame is in flight are dropped. All outputs are registered.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic     clk,
    input  logic     r_reset,
    uart_tx_if.slave bus
);

    localparam int unsigned        BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic               STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              stop_q;
    logic [0:7]        shift_q;
    logic              tx_q, busy_q, done_q;
    logic              baud_wrap, next_data, parity_bit;

    assign baud_d     = baud_q + BAUD_W'(1);
    assign bit_d      = bit_q + 3'd1;
    assign baud_wrap  = (baud_q == BAUD_LAST);
    // Index 7 holds the numeric LSB, so data bit k is found at index 7-k.
    assign next_data  = shift_q[3'd7 - bit_d];
    assign parity_bit = (^shift_q) ^ (PARITY_ODD != 0);

    // NOTE: every register is assigned with <= so that all state updates together on the edge.
    always_ff @(posedge clk) begin
        if (r_reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.i_start) begin
                        shift_q <= bus.i_uart_data;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        tx_q    <= shift_q[7];
                        state_q <= DATA;
                    end else begin
                        baud_q <= baud_d;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx_q    <= parity_bit;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                stop_q  <= 1'b0;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_q <= bit_d;
                            tx_q  <= next_data;
                        end
                    end else begin
                        baud_q <= baud_d;
                    end
                end
                PARITY: begin
                    if (baud_wrap) begin
                        baud_q  <= '0;
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= STOP;
                    end else begin
                        baud_q <= baud_d;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        baud_q <= '0;
                        if (stop_q == STOP_LAST) begin
                            stop_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        baud_q <= baud_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_tx   = tx_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;

endmodule
